// File: rtl/vm_thread_scheduler.sv
// Per-frame thread scheduler: 64-cycle APPLY of pending requests, then a SCAN/ISSUE/WAIT dispatch loop.
// run_* are registered and held until run_ready; the channel range iterator drops chan_ready while busy.
module vm_thread_scheduler #(
  parameter int NUM_THREADS = 64,
  parameter int PC_W        = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           frame_start,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           run_valid,
  input  logic                           run_ready,
  output logic [$clog2(NUM_THREADS)-1:0] run_thread,
  output logic [PC_W-1:0]                run_pc,
  input  logic                           yield_valid,
  input  logic                           yield_kill,
  input  logic [PC_W-1:0]                yield_pc,
  input  logic                           setvec_valid,
  input  logic [$clog2(NUM_THREADS)-1:0] setvec_thread,
  input  logic [PC_W-1:0]                setvec_pc,
  input  logic                           chan_valid,
  output logic                           chan_ready,
  input  logic [$clog2(NUM_THREADS)-1:0] chan_first,
  input  logic [$clog2(NUM_THREADS)-1:0] chan_last,
  input  logic [1:0]                     chan_op
);
  localparam int              IW      = $clog2(NUM_THREADS);
  localparam logic [IW-1:0]   LAST    = IW'(NUM_THREADS - 1);
  localparam logic [PC_W-1:0] PC_NONE = '1;
  localparam logic [PC_W-1:0] PC_KILL = PC_NONE - PC_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_SCAN, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [PC_W-1:0]        cur_pc  [NUM_THREADS];
  logic [PC_W-1:0]        req_pc  [NUM_THREADS];
  logic [NUM_THREADS-1:0] cur_pause;
  logic [NUM_THREADS-1:0] req_pause;
  logic                   chan_busy;
  logic [IW-1:0]          chan_idx;
  logic [IW-1:0]          chan_end;
  logic [1:0]             chan_op_q;

  assign chan_ready = ~chan_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      run_valid  <= 1'b0;
      run_thread <= '0;
      run_pc     <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        cur_pc[i] <= (i == 0) ? '0 : PC_NONE;
        req_pc[i] <= PC_NONE;
      end
      cur_pause  <= '0;
      req_pause  <= '0;
      chan_busy  <= 1'b0;
      chan_idx   <= '0;
      chan_end   <= '0;
      chan_op_q  <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (frame_start) begin
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_APPLY;
          end
        end
        S_APPLY: begin
          // The request clear sits before the chan/setvec writes below so a same-cycle write survives.
          if (req_pc[idx] != PC_NONE) begin
            cur_pc[idx] <= (req_pc[idx] == PC_KILL) ? PC_NONE : req_pc[idx];
            req_pc[idx] <= PC_NONE;
          end
          cur_pause[idx] <= req_pause[idx];
          idx <= (idx == LAST) ? '0 : idx + IW'(1);
          if (idx == LAST) state <= S_SCAN;
        end
        S_SCAN: begin
          if (cur_pc[idx] != PC_NONE && !cur_pause[idx]) begin
            run_valid  <= 1'b1;
            run_thread <= idx;
            run_pc     <= cur_pc[idx];
            state      <= S_ISSUE;
          end else if (idx == LAST) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_ISSUE: begin
          if (run_ready) begin
            run_valid <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (yield_valid) begin
            cur_pc[idx] <= yield_kill ? PC_NONE : yield_pc;
            if (idx == LAST) begin
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              idx   <= idx + IW'(1);
              state <= S_SCAN;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      if (chan_busy) begin
        case (chan_op_q)
          2'd0:    req_pause[chan_idx] <= 1'b0;
          2'd1:    req_pause[chan_idx] <= 1'b1;
          2'd2:    req_pc[chan_idx]    <= PC_KILL;
          default: ;
        endcase
        if (chan_idx == chan_end) chan_busy <= 1'b0;
        else                      chan_idx  <= chan_idx + IW'(1);
      end else if (chan_valid && chan_last >= chan_first && chan_op != 2'd3) begin
        chan_busy <= 1'b1;
        chan_idx  <= chan_first;
        chan_end  <= chan_last;
        chan_op_q <= chan_op;
      end

      // Last write to req_pc in the block, so setVec beats a same-cycle channel kill.
      if (setvec_valid) req_pc[setvec_thread] <= setvec_pc;
    end
  end
endmodule

// File: tb/tb_vm_thread_scheduler.sv
// Bench for vm_thread_scheduler: event-timed reference model, directed scenarios, then randomized frames.
module tb_vm_thread_scheduler;
  logic        clk = 1'b0;
  logic        reset, frame_start, frame_done, busy, run_valid, run_ready;
  logic [5:0]  run_thread;
  logic [15:0] run_pc;
  logic        yield_valid, yield_kill;
  logic [15:0] yield_pc;
  logic        setvec_valid;
  logic [5:0]  setvec_thread;
  logic [15:0] setvec_pc;
  logic        chan_valid, chan_ready;
  logic [5:0]  chan_first, chan_last;
  logic [1:0]  chan_op;

  always #5 clk = ~clk;

  vm_thread_scheduler #(.NUM_THREADS(64), .PC_W(16)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .frame_done(frame_done), .busy(busy),
    .run_valid(run_valid), .run_ready(run_ready), .run_thread(run_thread), .run_pc(run_pc),
    .yield_valid(yield_valid), .yield_kill(yield_kill), .yield_pc(yield_pc),
    .setvec_valid(setvec_valid), .setvec_thread(setvec_thread), .setvec_pc(setvec_pc),
    .chan_valid(chan_valid), .chan_ready(chan_ready), .chan_first(chan_first),
    .chan_last(chan_last), .chan_op(chan_op)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: thread state plus edge-timestamped frame plan ----------------
  localparam logic [15:0] NONE  = 16'hFFFF;
  localparam logic [15:0] KILLV = 16'hFFFE;
  logic [15:0] m_cur [64];
  logic [15:0] m_req [64];
  bit          m_cpause [64];
  bit          m_rpause [64];
  int          e = 0, f, s, c, issue_at, done_at, mi, mr;
  bit          m_busy, m_done, m_rv, m_wait, m_cb;
  logic [5:0]  m_thr;
  logic [15:0] m_pc;
  int          m_ci, m_cl;
  logic [1:0]  m_cop;
  int          rq[$];

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_cur[i] = (i == 0) ? 16'h0000 : NONE;
      m_req[i] = NONE;
      m_cpause[i] = 0;
      m_rpause[i] = 0;
    end
    m_busy = 0; m_done = 0; m_rv = 0; m_wait = 0; m_cb = 0;
    issue_at = -1; done_at = -1;
    rq.delete();
  endtask

  // Scan cursor c starts being examined in the cycle after edge s; one cycle per skipped thread.
  task automatic plan_next();
    if (rq.size() == 0) begin
      done_at = s + 64 - c;
      issue_at = -1;
    end else begin
      issue_at = s + (rq[0] - c) + 1;
      done_at = -1;
    end
  endtask

  always @(posedge clk) begin
    e++;
    if (reset) m_reset();
    else begin
      if (!m_busy) begin
        if (frame_start) begin m_busy = 1; f = e; end
      end else if (m_done) begin
        m_done = 0; m_busy = 0;
      end else if (e <= f + 64) begin
        mi = e - f - 1;
        if (m_req[mi] != NONE) begin
          m_cur[mi] = (m_req[mi] == KILLV) ? NONE : m_req[mi];
          m_req[mi] = NONE;
        end
        m_cpause[mi] = m_rpause[mi];
        if (e == f + 64) begin
          rq.delete();
          for (int j = 0; j < 64; j++) if (m_cur[j] != NONE && !m_cpause[j]) rq.push_back(j);
          s = e; c = 0;
          plan_next();
        end
      end else if (e == done_at) begin
        m_done = 1;
      end else if (e == issue_at) begin
        m_rv = 1; m_thr = 6'(rq[0]); m_pc = m_cur[rq[0]];
      end else if (m_rv) begin
        if (run_ready) begin m_rv = 0; m_wait = 1; end
      end else if (m_wait && yield_valid) begin
        mr = rq.pop_front();
        m_cur[mr] = yield_kill ? NONE : yield_pc;
        m_wait = 0;
        if (mr == 63) m_done = 1;
        else begin s = e; c = mr + 1; plan_next(); end
      end
      if (m_cb) begin
        if (m_cop == 2'd0) m_rpause[m_ci] = 0;
        else if (m_cop == 2'd1) m_rpause[m_ci] = 1;
        else if (m_cop == 2'd2) m_req[m_ci] = KILLV;
        if (m_ci == m_cl) m_cb = 0; else m_ci++;
      end else if (chan_valid && chan_last >= chan_first && chan_op != 2'd3) begin
        m_cb = 1; m_ci = chan_first; m_cl = chan_last; m_cop = chan_op;
      end
      if (setvec_valid) m_req[setvec_thread] = setvec_pc;
    end
  end

  task automatic compare();
    chk("frame_done", frame_done, m_done);
    chk("busy", busy, m_busy);
    chk("run_valid", run_valid, m_rv);
    chk("chan_ready", chan_ready, !m_cb);
    if (m_rv) begin
      chk("run_thread", run_thread, m_thr);
      chk("run_pc", run_pc, m_pc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  // ---------------- stimulus helpers ----------------
  int pc_ovr [64];
  bit kill_mask [64];
  int disp_t[$];
  int disp_p[$];

  task automatic clr_pulses();
    frame_start = 0; yield_valid = 0; yield_kill = 0; setvec_valid = 0; chan_valid = 0;
  endtask

  task automatic clr_cpu();
    for (int i = 0; i < 64; i++) begin pc_ovr[i] = -1; kill_mask[i] = 0; end
  endtask

  task automatic do_setvec(input int t, input int pc);
    setvec_valid = 1; setvec_thread = 6'(t); setvec_pc = 16'(pc);
    tick();
    setvec_valid = 0;
  endtask

  task automatic do_chan(input int a, input int b, input int op, output int low);
    chan_valid = 1; chan_first = 6'(a); chan_last = 6'(b); chan_op = 2'(op);
    tick();
    chan_valid = 0;
    low = 0;
    while (!chan_ready && low < 100) begin low++; tick(); end
  endtask

  task automatic side_traffic();
    if ($urandom_range(0, 7) == 0) begin
      setvec_valid = 1; setvec_thread = 6'($urandom_range(0, 63));
      setvec_pc = ($urandom_range(0, 15) == 0) ? KILLV : 16'($urandom_range(0, 16'h7FFF));
    end
    if ($urandom_range(0, 9) == 0) begin
      chan_valid = 1; chan_first = 6'($urandom_range(0, 63));
      chan_last = 6'($urandom_range(0, 63)); chan_op = 2'($urandom_range(0, 3));
    end
  endtask

  // Acts as the CPU for one frame; rst_at >= 0 aborts the frame with a reset pulse.
  task automatic run_frame(input bit rnd, input int rst_at, input int sv_at, input int sv_t, input int sv_p);
    bit waiting, hs, fin;
    int cur_t;
    disp_t.delete(); disp_p.delete();
    waiting = 0; fin = 0; cur_t = 0;
    frame_start = 1; tick(); frame_start = 0;
    for (int n = 0; n < 6000 && !fin; n++) begin
      if (frame_done) fin = 1;
      else if (n == rst_at) begin
        reset = 1; tick(); reset = 0; fin = 1;
      end else begin
        run_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (waiting) yield_valid = rnd ? ($urandom_range(0, 1) == 0) : 1'b1;
        else yield_valid = rnd && ($urandom_range(0, 15) == 0);
        yield_kill = kill_mask[cur_t];
        yield_pc = (pc_ovr[cur_t] >= 0) ? 16'(pc_ovr[cur_t]) : 16'($urandom_range(0, 16'h7FFF));
        if (rnd) side_traffic();
        if (n == sv_at) begin setvec_valid = 1; setvec_thread = 6'(sv_t); setvec_pc = 16'(sv_p); end
        hs = run_valid && run_ready;
        if (hs) begin cur_t = run_thread; disp_t.push_back(run_thread); disp_p.push_back(run_pc); end
        if (waiting && yield_valid) waiting = 0;
        tick();
        if (hs) waiting = 1;
        clr_pulses();
      end
    end
    if (!fin) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: frame_done never seen within 6000 cycles");
    end
    clr_pulses(); run_ready = 0;
    tick();
  endtask

  task automatic chk_disp(input string nm, input int k, input int thr, input int pc);
    n_chk++;
    if (k >= disp_t.size()) begin
      n_fail++;
      $display("FAIL %s: dispatch %0d missing, got %0d dispatches", nm, k, disp_t.size());
    end else begin
      chk({nm, "_thr"}, disp_t[k], thr);
      chk({nm, "_pc"}, disp_p[k], pc);
    end
  endtask

  initial begin
    int low, k, hold_t, hold_p;
    reset = 1; run_ready = 0; yield_pc = 0; setvec_thread = 0; setvec_pc = 0;
    chan_first = 0; chan_last = 0; chan_op = 0;
    clr_pulses(); clr_cpu();
    repeat (3) tick();
    reset = 0;
    tick();
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_run_valid", run_valid, 0);
    chk("rst_run_thread", run_thread, 0);
    chk("rst_run_pc", run_pc, 0);
    chk("rst_chan_ready", chan_ready, 1);

    // Frame 1: only thread 0; setVec 5 lands during APPLY and must wait a frame.
    pc_ovr[0] = 16'h0123;
    run_frame(0, -1, 5, 5, 16'h0040);
    chk("f1_count", disp_t.size(), 1);
    chk_disp("f1_d0", 0, 0, 16'h0000);

    clr_cpu(); pc_ovr[0] = 16'h0200; pc_ovr[5] = 16'h0050;
    run_frame(0, -1, -1, 0, 0);
    chk("f2_count", disp_t.size(), 2);
    chk_disp("f2_d0", 0, 0, 16'h0123);
    chk_disp("f2_d1", 1, 5, 16'h0040);

    do_chan(3, 7, 1, low);
    chk("freeze_low_cycles", low, 5);
    clr_cpu(); pc_ovr[0] = 16'h0300;
    run_frame(0, -1, -1, 0, 0);
    chk("f3_count", disp_t.size(), 1);
    chk_disp("f3_d0", 0, 0, 16'h0200);

    do_chan(3, 7, 0, low);
    chk("unfreeze_low_cycles", low, 5);
    do_chan(9, 4, 1, low);
    chk("reversed_range_low", low, 0);
    clr_cpu(); kill_mask[0] = 1; pc_ovr[5] = 16'h0051;
    run_frame(0, -1, -1, 0, 0);
    chk("f4_count", disp_t.size(), 2);
    chk_disp("f4_d0", 0, 0, 16'h0300);
    chk_disp("f4_d1", 1, 5, 16'h0050);

    do_chan(5, 5, 2, low);
    chk("kill_low_cycles", low, 1);
    do_setvec(5, 16'h0010);
    clr_cpu(); kill_mask[5] = 1;
    run_frame(0, -1, -1, 0, 0);
    chk("f5_count", disp_t.size(), 1);
    chk_disp("f5_d0", 0, 5, 16'h0010);

    // Empty frame: done exactly 128 edges after the sampling edge; a pulse while busy is ignored.
    frame_start = 1; tick(); frame_start = 0;
    k = 0;
    while (!frame_done && k < 300) begin
      frame_start = (k == 20);
      k++;
      tick();
    end
    frame_start = 0;
    chk("empty_done_edge", k, 128);
    tick();
    chk("empty_idle_busy", busy, 0);
    repeat (3) tick();
    chk("ignored_start_busy", busy, 0);

    // Backpressure then reset during WAIT.
    do_setvec(0, 16'h0777);
    frame_start = 1; tick(); frame_start = 0;
    k = 0;
    while (!run_valid && k < 400) begin k++; tick(); end
    chk("bp_run_valid", run_valid, 1);
    chk("bp_thread", run_thread, 0);
    chk("bp_pc", run_pc, 16'h0777);
    hold_t = run_thread; hold_p = run_pc;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_stable_valid", run_valid, 1);
      chk("bp_stable_thread", run_thread, hold_t);
      chk("bp_stable_pc", run_pc, hold_p);
    end
    run_ready = 1; tick(); run_ready = 0;
    tick();
    reset = 1; tick(); reset = 0;
    chk("rst_wait_run_valid", run_valid, 0);
    chk("rst_wait_busy", busy, 0);
    clr_cpu();
    run_frame(0, -1, -1, 0, 0);
    chk("post_rst_count", disp_t.size(), 1);
    chk_disp("post_rst_d0", 0, 0, 16'h0000);

    // Randomized frames with background setVec/channel traffic and one mid-frame reset.
    for (int fr = 0; fr < 24; fr++) begin
      clr_cpu();
      for (int i = 0; i < 64; i++) kill_mask[i] = ($urandom_range(0, 5) == 0);
      run_frame(1, (fr == 9) ? $urandom_range(10, 300) : -1, -1, 0, 0);
      for (int i = $urandom_range(0, 6); i > 0; i--) begin
        side_traffic(); tick(); clr_pulses();
      end
      while (!chan_ready && k < 100000) begin k++; tick(); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
